// File: rtl/pixel_to_block.sv
// pixel_to_block: collects a pixel stream into an M*M block and hands it off with valid/ack.
// Optional PIXEL_TO_BLOCK_CLEAR_EN zeroes block_out on each ack so unused slots read 0.
module pixel_to_block #(
  parameter int Data_Depth = 8,
  parameter int Max_M      = 72
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [19:0]                         M2,
  input  logic [Data_Depth-1:0]               pixel_in,
  input  logic                                pixel_valid,
  output logic                                pixel_ready,
  input  logic                                last_block,
  output logic [Data_Depth*Max_M*Max_M-1:0]   block_out,
  output logic                                block_valid,
  input  logic                                block_ack,
  output logic                                size_err,
  output logic                                image_done
);
  localparam logic [19:0] MaxPix = 20'(Max_M * Max_M);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  state_t r_state, w_next;
  logic [19:0] r_count, r_m2;
  logic [Data_Depth*Max_M*Max_M-1:0] r_block;
  logic r_ready, r_valid, r_size_err, r_done, r_last;
  logic w_accept, w_bad, w_final, w_ack;
  logic [19:0] w_m2_eff, w_size;
  assign w_accept = pixel_valid && r_ready;
  assign w_bad    = (M2 == 20'd0) || (M2 > MaxPix);
  assign w_m2_eff = w_bad ? MaxPix : M2;
  // the first pixel of a block compares against the incoming size, later ones against the latched size
  assign w_size   = (r_state == IDLE) ? w_m2_eff : r_m2;
  assign w_final  = (r_count + 20'd1) == w_size;
  assign w_ack    = (r_state == FULL) && block_ack;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? (w_final ? FULL : FILL) : IDLE;
      FILL:    w_next = (w_accept && w_final) ? FULL : FILL;
      FULL:    w_next = block_ack ? IDLE : FULL;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_m2       <= '0;
      r_block    <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_size_err <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_ready <= (w_next != FULL);
      r_valid <= (w_next == FULL);
      if (w_accept) begin
        r_block[r_count*Data_Depth +: Data_Depth] <= pixel_in;
        r_count <= r_count + 20'd1;
        if (w_final) r_last <= last_block;
        if (r_state == IDLE) begin
          r_m2       <= w_m2_eff;
          r_size_err <= r_size_err | w_bad;
          r_done     <= 1'b0;
        end
      end
      if (w_ack) begin
        r_count <= '0;
        if (r_last) r_done <= 1'b1;
`ifdef PIXEL_TO_BLOCK_CLEAR_EN
        r_block <= '0;
`else
        r_block <= r_block;
`endif
      end
    end
  end
  assign pixel_ready = r_ready;
  assign block_valid = r_valid;
  assign block_out   = r_block;
  assign size_err    = r_size_err;
  assign image_done  = r_done;
endmodule
